membrane_accum: RTL and testbench

Clocked membrane-potential accumulator that sits directly upstream of the PE spike/residue threshold stage. Per output neuron it sums incoming partial sums onto that neuron's stored residue. It then sends the resulting potential downstream for thresholding and writes back the residue the threshold stage returns. It holds the per-neuron residue state across timesteps.

---
 rtl/membrane_accum.sv | 152 +++++++++++++++
 tb/tb_membrane_accum.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/membrane_accum.sv
// Membrane-potential accumulator: sums partial sums onto a per-neuron residue, sends the potential
// downstream and stores the returned residue. Optional leak on the first beat: `define MEMBRANE_LEAK_EN.
module membrane_accum #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PSUM_WIDTH  = 8,
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  parameter int unsigned LEAK        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psum_valid,
  output logic                  psum_ready,
  input  logic [PSUM_WIDTH-1:0] psum_data,
  input  logic [IDX_W-1:0]      psum_idx,
  input  logic                  psum_last,
  output logic                  pot_valid,
  input  logic                  pot_ready,
  output logic [WIDTH-1:0]      pot_data,
  output logic [IDX_W-1:0]      pot_idx,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [WIDTH-1:0]      res_data,
  output logic                  idx_err,
  output logic                  busy
);

  localparam int unsigned SUM_W = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, SEND, WAIT_RES} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic [WIDTH-1:0] res_q [NUM_NEURONS];
  logic [WIDTH-1:0] res_d [NUM_NEURONS];
  logic             psum_ready_q, psum_ready_d;
  logic             pot_valid_q, pot_valid_d;
  logic             res_ready_q, res_ready_d;
  logic             idx_err_q, idx_err_d;
  logic             busy_q, busy_d;

  logic             psum_hs;
  logic             idx_ok;
  logic [WIDTH-1:0] res_sel;
  logic [WIDTH-1:0] base;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [PSUM_WIDTH-1:0] p);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(p);
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  assign psum_hs = psum_valid && psum_ready_q;
  assign idx_ok  = 32'(psum_idx) < NUM_NEURONS;

  // Starting value for the first beat of a neuron
  always_comb begin
    res_sel = '0;
    if (idx_ok) res_sel = res_q[psum_idx];
`ifdef MEMBRANE_LEAK_EN
    base = (res_sel > WIDTH'(LEAK)) ? res_sel - WIDTH'(LEAK) : '0;
`else
    base = res_sel;
`endif
  end

`ifndef MEMBRANE_LEAK_EN
  logic unused_leak;
  assign unused_leak = ^WIDTH'(LEAK);
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cur_idx_d = cur_idx_q;
    res_d     = res_q;
    idx_err_d = idx_err_q;
    case (state_q)
      IDLE: begin
        if (psum_hs) begin
          if (!idx_ok) begin
            idx_err_d = 1'b1;
          end else begin
            cur_idx_d = psum_idx;
            acc_d     = sat_add(base, psum_data);
            state_d   = psum_last ? SEND : ACCUM;
          end
        end
      end
      ACCUM: begin
        if (psum_hs) begin
          if (psum_idx != cur_idx_q) begin
            idx_err_d = 1'b1;
          end else begin
            acc_d = sat_add(acc_q, psum_data);
            if (psum_last) state_d = SEND;
          end
        end
      end
      SEND: begin
        if (pot_valid_q && pot_ready) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_valid && res_ready_q) begin
          res_d[cur_idx_q] = res_data;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered from the next state so they line up with state_q
    psum_ready_d = (state_d == IDLE) || (state_d == ACCUM);
    pot_valid_d  = (state_d == SEND);
    res_ready_d  = (state_d == WAIT_RES);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cur_idx_q    <= '0;
      psum_ready_q <= 1'b0;
      pot_valid_q  <= 1'b0;
      res_ready_q  <= 1'b0;
      idx_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < int'(NUM_NEURONS); i++) res_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cur_idx_q    <= cur_idx_d;
      psum_ready_q <= psum_ready_d;
      pot_valid_q  <= pot_valid_d;
      res_ready_q  <= res_ready_d;
      idx_err_q    <= idx_err_d;
      busy_q       <= busy_d;
      res_q        <= res_d;
    end
  end

  assign psum_ready = psum_ready_q;
  assign pot_valid  = pot_valid_q;
  assign pot_data   = acc_q;
  assign pot_idx    = cur_idx_q;
  assign res_ready  = res_ready_q;
  assign idx_err    = idx_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_membrane_accum.sv
// Self-checking bench for membrane_accum: directed plan steps plus randomized neurons against a
// per-neuron residue model.
module tb_membrane_accum;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PW    = 8;
  localparam int unsigned NN    = 4;
  localparam int unsigned IW    = 2;
  localparam int unsigned LEAK  = 1;
  localparam int          MAXV  = 255;
  localparam int          BOUND = 50;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psum_valid, psum_ready, psum_last;
  logic [PW-1:0] psum_data;
  logic [IW-1:0] psum_idx;
  logic          pot_valid, pot_ready;
  logic [WIDTH-1:0] pot_data;
  logic [IW-1:0] pot_idx;
  logic          res_valid, res_ready;
  logic [WIDTH-1:0] res_data;
  logic          idx_err, busy;

  int checks = 0;
  int errors = 0;
  int model_res [NN];

  always #5 clk = ~clk;

  membrane_accum #(.WIDTH(WIDTH), .PSUM_WIDTH(PW), .NUM_NEURONS(NN), .IDX_W(IW), .LEAK(LEAK)) dut (
    .clk(clk), .rst_n(rst_n),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .psum_idx(psum_idx), .psum_last(psum_last),
    .pot_valid(pot_valid), .pot_ready(pot_ready), .pot_data(pot_data), .pot_idx(pot_idx),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .idx_err(idx_err), .busy(busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int start_value(input int r);
`ifdef MEMBRANE_LEAK_EN
    return (r > int'(LEAK)) ? r - int'(LEAK) : 0;
`else
    return r;
`endif
  endfunction

  function automatic int clamp(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // One psum beat; returns after the accepting edge (+1 time unit)
  task automatic psum_beat(input int idx, input int data, input bit last);
    int n = 0;
    @(negedge clk);
    psum_valid = 1'b1; psum_idx = IW'(idx); psum_data = PW'(data); psum_last = last;
    while (psum_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) check("psum_ready_timeout", 0, 1);
    @(posedge clk); #1;
    psum_valid = 1'b0; psum_last = 1'b0;
  endtask

  // Wait for a potential, hold it off for `hold` cycles, then take it
  task automatic take_pot(input int exp_data, input int exp_idx, input int hold);
    int n = 0;
    @(negedge clk);
    while (pot_valid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) check("pot_valid_timeout", 0, 1);
    check("pot_data", int'(pot_data), exp_data);
    check("pot_idx", int'(pot_idx), exp_idx);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", int'(pot_valid), 1);
      check("hold_data", int'(pot_data), exp_data);
      check("hold_idx", int'(pot_idx), exp_idx);
      check("hold_psum_ready", int'(psum_ready), 0);
    end
    pot_ready = 1'b1;
    @(posedge clk); #1;
    pot_ready = 1'b0;
  endtask

  task automatic give_res(input int idx, input int val);
    int n = 0;
    @(negedge clk);
    res_valid = 1'b1; res_data = WIDTH'(val);
    while (res_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) check("res_ready_timeout", 0, 1);
    @(posedge clk); #1;
    res_valid = 1'b0;
    model_res[idx] = val;
  endtask

  // Full neuron transaction with model-derived expected potential
  task automatic neuron(input int idx, input int d0, input int d1, input int d2, input int nb,
                        input int hold, input int ret);
    int total;
    int d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    total = start_value(model_res[idx]);
    for (int i = 0; i < nb; i++) begin
      total += d[i];
      psum_beat(idx, d[i], i == nb - 1);
    end
    check("pot_latency", int'(pot_valid), 1);
    take_pot(clamp(total), idx, hold);
    give_res(idx, ret);
  endtask

  task automatic check_reset_outputs();
    check("rst_pot_valid", int'(pot_valid), 0);
    check("rst_pot_data", int'(pot_data), 0);
    check("rst_pot_idx", int'(pot_idx), 0);
    check("rst_res_ready", int'(res_ready), 0);
    check("rst_idx_err", int'(idx_err), 0);
    check("rst_psum_ready", int'(psum_ready), 0);
    check("rst_busy", int'(busy), 0);
  endtask

  initial begin
    int base2;
    rst_n = 1'b0; psum_valid = 1'b0; psum_data = '0; psum_idx = '0; psum_last = 1'b0;
    pot_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    for (int i = 0; i < int'(NN); i++) model_res[i] = 0;
    #23;
    check_reset_outputs();
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_psum_ready", int'(psum_ready), 1);
    check("idle_busy", int'(busy), 0);

    // Basic accumulation, residue writeback, reuse of the stored residue
    neuron(0, 10, 20, 30, 3, 0, 60);
    neuron(0, 10, 0, 0, 1, 0, 6);
    neuron(0, 5, 0, 0, 1, 0, 40);
    // Saturation
    neuron(1, 200, 100, 0, 2, 0, 0);

    // Backpressure hold with a stray residue that must be ignored
    psum_beat(3, 7, 1'b1);
    res_valid = 1'b1; res_data = 8'd99;
    @(negedge clk);
    check("res_ready_in_send", int'(res_ready), 0);
    check("busy_in_send", int'(busy), 1);
    res_valid = 1'b0;
    take_pot(clamp(start_value(model_res[3]) + 7), 3, 5);
    @(negedge clk);
    check("pot_valid_after_hs", int'(pot_valid), 0);
    check("res_ready_wait", int'(res_ready), 1);
    give_res(3, 33);

    // Index mismatch inside ACCUM: discarded, its psum_last ignored, idx_err sticky
    base2 = start_value(model_res[2]);
    psum_beat(2, 4, 1'b0);
    psum_beat(3, 50, 1'b1);
    @(negedge clk);
    check("mismatch_no_send", int'(pot_valid), 0);
    check("mismatch_idx_err", int'(idx_err), 1);
    psum_beat(2, 6, 1'b1);
    take_pot(clamp(base2 + 10), 2, 0);
    give_res(2, 12);

    // Randomized neurons
    for (int t = 0; t < 25; t++) begin
      neuron(int'($urandom_range(0, NN - 1)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 40)),
             int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 255)));
    end
    @(negedge clk);
    check("idx_err_sticky", int'(idx_err), 1);

    // Reset while waiting for the residue
    psum_beat(1, 9, 1'b1);
    take_pot(clamp(start_value(model_res[1]) + 9), 1, 0);
    @(negedge clk);
    check("in_wait_res", int'(res_ready), 1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs();
    for (int i = 0; i < int'(NN); i++) model_res[i] = 0;
    @(negedge clk); rst_n = 1'b1;
    neuron(1, 9, 0, 0, 1, 0, 0);
    neuron(0, 5, 0, 0, 1, 0, 60);
    neuron(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("idx_err_cleared", int'(idx_err), 0);
    check("final_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
